seq_arith_unit_16bit: RTL
=========================

// Module: seq_arith_unit_16bit
// PURPOSE
//  Multi-cycle arithmetic sequencer that feeds and time-shares one adder_subtractor_16bit.
//  Accepts an operation and two 16-bit operands on a start pulse and runs 1 or 2 adder passes.
//  Computes A+B, A-B, B-2A (two passes) or accumulate ACC+A.
//  Registers the result, carry and signed overflow, then pulses Done.
//  Sits between the lab's switch/operand capture logic and the result display.
// PARAMETERS
//  WIDTH       16  datapath width; only 16 is supported (fixed by the adder).
//  OVF_STICKY  0   0: Ovf shows the last op only; 1: Ovf ORs across ops until Clr or RST.
// PORTS
//  CLK    in   1   single clock; all state changes on its rising edge.
//  RST    in   1   asynchronous, active-high reset.
//  Start  in   1   request; sampled only in IDLE.
//  Op     in   2   00 ADD A+B, 01 SUB A-B, 10 BM2A B-2A, 11 ACC ACC+A.
//  A      in   16  operand A; latched on the accepted Start edge.
//  B      in   16  operand B; latched on the accepted Start edge.
//  Clr    in   1   sync clear of ACC (and sticky Ovf); honoured only in IDLE.
//  Out    out  16  registered result.
//  Cout   out  1   adder carry-out of the final pass (SUB: 1 = no borrow).
//  Ovf    out  1   signed two's-complement overflow.
//  Busy   out  1   high while an operation is in flight.
//  Done   out  1   one-cycle pulse; Out/Cout/Ovf are valid from that cycle on.
// BEHAVIOUR
//  Reset (async, immediate): Out=0, Cout=0, Ovf=0, Busy=0, Done=0, ACC=0, state=IDLE.
//  States:
//   IDLE: Start=1 latches A, B and Op into opA/opB/opR, sets Busy=1, goes to P1.
//   P1: one adder pass.
//     ADD: opA+opB, Cin=0.
//     SUB: opA+~opB+1, Cin=1.
//     ACC: ACC+opA, Cin=0.
//     BM2A: T=opB-opA, Cin=1; T, its carry and its overflow are stored in tmp regs.
//     ADD/SUB/ACC then go to WB; BM2A goes to P2.
//   P2 (BM2A only): T-opA, Cin=1, then go to WB.
//   WB: clocks Out, Cout, Ovf; sets Done=1 and Busy=0 on the same edge; ACC updated for op 11.
//     Returns to IDLE, where Done drops after one cycle.
//  Latency from the Start sample edge N:
//   ADD/SUB/ACC: Out and Done update at edge N+2.
//   BM2A: Out and Done update at edge N+3.
//  Back-to-back: Start high during the Done cycle is accepted (state is IDLE).
//  Start while Busy=1 is ignored; requests are not queued.
//  A/B/Op changes after acceptance have no effect.
//  Ovf = (sa==sb) && (sr!=sa), where sa/sb are the signs of the adder inputs after B-inversion.
//   BM2A reports Ovf = ovf_p1 | ovf_p2.
//  Clr in IDLE: ACC=0 at the next edge, plus Ovf=0 when OVF_STICKY=1.
//   Clr while Busy is ignored; Out is never cleared by Clr.
//   Clr and Start in the same IDLE edge: clear applies first, so ACC op uses ACC=0.
//  Arithmetic wraps modulo 2^16; Cout is reported, never saturated.
//  RST mid-operation aborts immediately: no Done, ACC=0.
// STRUCTURE
//  Package arith_seq_pkg:
//   OP_ADD=2'b00, OP_SUB=2'b01, OP_BM2A=2'b10, OP_ACC=2'b11.
//   State encodings S_IDLE, S_P1, S_P2, S_WB (2-bit).
//   WIDTH constant.
//  One sub-module: a single existing adder_subtractor_16bit instance, time-shared.
//   Its Cin drives both B-inversion and carry-in.
//   Front operand mux selects {opA, opB, ACC, T} per state/op.
//  Local logic: FSM, operand/tmp/ACC regs, overflow logic.
// TESTING
//  1 ADD A=0x0005 B=0x0003 -> Out=0x0008 Cout=0 Ovf=0; Done at N+2, high one cycle.
//  2 SUB A=0x0003 B=0x0005 -> Out=0xFFFE Cout=0 Ovf=0; SUB A=0x8000 B=0x0001 -> Out=0x7FFF Ovf=1.
//  3 BM2A A=0x0004 B=0x0010 -> Out=0x0008 Cout=1 Ovf=0; Done at N+3, Busy high edges N..N+3.
//  4 ADD A=0x7FFF B=0x0001 -> Out=0x8000 Cout=0 Ovf=1.
//    With OVF_STICKY=1 a following ADD 1+1 keeps Ovf=1 until Clr.
//  5 Clr, then ACC A=0x0010 three times back-to-back (Start in each Done cycle) -> Out 0x0010, 0x0020, 0x0030.
//    A Start pulse mid-op is ignored (still exactly 3 Dones).
//  6 BM2A started, RST pulsed at N+1 -> all outputs 0 asynchronously, no Done.
//    Next ADD 1+2 -> Out=0x0003 normally.

Source files
------------

// File: rtl/arith_seq_pkg.sv
// Shared types and constants for the 16-bit sequential arithmetic unit.
// Contents: datapath width, opcode and state encodings, adder request
// payload, and the signed-overflow helper used on every adder pass.
package arith_seq_pkg;

  localparam int unsigned WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_BM2A = 2'b10,
    OP_ACC  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_P1   = 2'b01,
    S_P2   = 2'b10,
    S_WB   = 2'b11
  } state_e;

  // One adder pass: cin=1 means subtract (b is inverted inside the adder).
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } add_req_t;

  // Signed overflow from operand signs as seen by the adder (b already inverted).
  function automatic logic sgn_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/adder_subtractor_16bit.sv
// 16-bit adder/subtractor: sum_c = a + (cin ? ~b : b) + cin.
// Ports:
//   a, b    in   operands
//   cin     in   selects subtract; also the carry-in
//   sum_c   out  combinational sum (mod 2^16)
//   cout_c  out  combinational carry-out (subtract: 1 = no borrow)
module adder_subtractor_16bit
  import arith_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff  = cin ? ~b : b;
    full   = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(cin);
    sum_c  = full[WIDTH-1:0];
    cout_c = full[WIDTH];
  end

endmodule

// File: rtl/seq_arith_unit_16bit.sv
// Multi-cycle arithmetic sequencer around one time-shared adder_subtractor_16bit.
// Ops: ADD A+B, SUB A-B, BM2A B-2A (two passes), ACC ACC+A.
// Ports:
//   CLK, RST      clock, async active-high reset
//   Start         request, sampled only in IDLE
//   Op, A, B      operation and operands, latched on the accepted Start edge
//   Clr           clear ACC (and sticky Ovf), honoured only in IDLE
//   Out/Cout/Ovf  registered result, final-pass carry, signed overflow
//   Busy          high while an operation is in flight
//   Done          one-cycle pulse when Out/Cout/Ovf update
module seq_arith_unit_16bit #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          OVF_STICKY = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Clr,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);
  import arith_seq_pkg::*;

  localparam int unsigned MSB = WIDTH - 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic             tmp_cout_q, tmp_cout_d;
  logic             tmp_ovf_q, tmp_ovf_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  add_req_t         req_c;
  logic [WIDTH-1:0] add_sum_c;
  logic             add_cout_c;
  logic             pass_ovf_c;

  // Operand mux: picks adder inputs for the current pass.
  always_comb begin
    req_c.a   = opa_q;
    req_c.b   = opb_q;
    req_c.cin = 1'b0;
    case (state_q)
      S_P1: begin
        case (op_q)
          OP_ADD: begin
            req_c.cin = 1'b0;
          end
          OP_SUB: begin
            req_c.cin = 1'b1;
          end
          OP_BM2A: begin
            // First pass of B-2A is T = B - A.
            req_c.a   = opb_q;
            req_c.b   = opa_q;
            req_c.cin = 1'b1;
          end
          OP_ACC: begin
            req_c.a = acc_q;
            req_c.b = opa_q;
          end
        endcase
      end
      S_P2: begin
        // Second pass of B-2A is T - A.
        req_c.a   = tmp_q;
        req_c.b   = opa_q;
        req_c.cin = 1'b1;
      end
      default: begin
        req_c.cin = 1'b0;
      end
    endcase
  end

  adder_subtractor_16bit u_adder (
    .a      (req_c.a),
    .b      (req_c.b),
    .cin    (req_c.cin),
    .sum_c  (add_sum_c),
    .cout_c (add_cout_c)
  );

  // b's sign after the adder's internal inversion is b[MSB] ^ cin.
  always_comb begin
    pass_ovf_c = sgn_ovf(req_c.a[MSB], req_c.b[MSB] ^ req_c.cin, add_sum_c[MSB]);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    tmp_d      = tmp_q;
    tmp_cout_d = tmp_cout_q;
    tmp_ovf_d  = tmp_ovf_q;
    out_d      = out_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // ACC is read only in P1, so a Clr on the Start edge is seen by ACC.
        if (Clr) begin
          acc_d = '0;
          if (OVF_STICKY) begin
            ovf_d = 1'b0;
          end
        end
        if (Start) begin
          opa_d   = A;
          opb_d   = B;
          op_d    = op_e'(Op);
          busy_d  = 1'b1;
          state_d = S_P1;
        end
      end
      S_P1: begin
        tmp_d      = add_sum_c;
        tmp_cout_d = add_cout_c;
        tmp_ovf_d  = pass_ovf_c;
        state_d    = (op_q == OP_BM2A) ? S_P2 : S_WB;
      end
      S_P2: begin
        tmp_d      = add_sum_c;
        tmp_cout_d = add_cout_c;
        tmp_ovf_d  = tmp_ovf_q | pass_ovf_c;
        state_d    = S_WB;
      end
      S_WB: begin
        out_d  = tmp_q;
        cout_d = tmp_cout_q;
        ovf_d  = OVF_STICKY ? (ovf_q | tmp_ovf_q) : tmp_ovf_q;
        if (op_q == OP_ACC) begin
          acc_d = tmp_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      tmp_q      <= '0;
      tmp_cout_q <= 1'b0;
      tmp_ovf_q  <= 1'b0;
      out_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      tmp_q      <= tmp_d;
      tmp_cout_q <= tmp_cout_d;
      tmp_ovf_q  <= tmp_ovf_d;
      out_q      <= out_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Out  = out_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
